// File: rtl/tl_sram_responder_pkg.sv
// Shared widths, TileLink opcodes and the D-channel response record for tl_sram_responder.
package tl_sram_responder_pkg;

  localparam int SOURCE_W = 7;
  localparam int ADDR_W   = 29;
  localparam int DATA_W   = 64;
  localparam int MASK_W   = 8;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  // use_rdata selects the SRAM read port as the data source; otherwise data reads as zero
  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic                corrupt;
    logic                use_rdata;
  } d_resp_t;

  function automatic logic [2:0] align_mask(input logic [2:0] size);
    case (size)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc);
    sat_inc = (inc && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
  endfunction

endpackage

// File: rtl/tl_sram_responder_mem.sv
// Single-port DEPTH x 64 SRAM with byte write enables and a registered read port.
// Latency: read data valid the cycle after en & !we; no backpressure (write and read exclusive per cycle).
module tl_sram_responder_mem
  import tl_sram_responder_pkg::*;
#(
  parameter int DEPTH = 512,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [MASK_W-1:0] be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array and read register are deliberately unreset so this maps onto a RAM macro
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (be[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata_q <= ram[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL single-beat SRAM responder; optional perf counters under TL_SRAM_RESPONDER_PERF_EN.
// Latency: response 1 cycle after A fire; a_ready drops only while the held D response is not accepted.
module tl_sram_responder
  import tl_sram_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 29'h0000_0000,
  parameter int                DEPTH     = 512
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                auto_in_a_valid,
  output logic                auto_in_a_ready,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [2:0]          auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [MASK_W-1:0]   auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  output logic                auto_in_d_valid,
  input  logic                auto_in_d_ready,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [1:0]          auto_in_d_bits_param,
  output logic [2:0]          auto_in_d_bits_size,
  output logic [SOURCE_W-1:0] auto_in_d_bits_source,
  output logic                auto_in_d_bits_sink,
  output logic                auto_in_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  output logic                auto_in_d_bits_corrupt
`ifdef TL_SRAM_RESPONDER_PERF_EN
  ,
  output logic [31:0]         perf_req_count,
  output logic [31:0]         perf_denied_count,
  output logic [31:0]         perf_stall_count
`endif
);

  localparam int               IDX_W     = $clog2(DEPTH);
  localparam int               AW1       = ADDR_W + 1;
  localparam logic [ADDR_W:0]  BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]  LIMIT_EXT = BASE_EXT + (AW1'(DEPTH) << 3);

  logic              a_fire;
  logic              d_fire;
  logic              op_get;
  logic              op_put;
  logic              legal;
  logic [ADDR_W:0]   addr_ext;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] rdata;
  logic              unused_a;

  d_resp_t resp_q, resp_d;
  logic    d_valid_q, d_valid_d;

  assign auto_in_a_ready = reset & (~d_valid_q | auto_in_d_ready);
  assign a_fire          = auto_in_a_valid & auto_in_a_ready;
  assign d_fire          = d_valid_q & auto_in_d_ready;
  assign unused_a        = ^{auto_in_a_bits_param, auto_in_a_bits_corrupt};

  // Range check runs one bit wider than the address so BASE + window cannot wrap
  always_comb begin
    addr_ext = {1'b0, auto_in_a_bits_address};
    op_get   = (auto_in_a_bits_opcode == GET);
    op_put   = (auto_in_a_bits_opcode == PUT_FULL) || (auto_in_a_bits_opcode == PUT_PARTIAL);
    legal    = (op_get || op_put)
             && (auto_in_a_bits_size <= 3'd3)
             && ((auto_in_a_bits_address[2:0] & align_mask(auto_in_a_bits_size)) == 3'b000)
             && (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
    offset   = auto_in_a_bits_address - BASE_ADDR;
    word_idx = IDX_W'(offset >> 3);
  end

  always_comb begin
    resp_d    = resp_q;
    d_valid_d = d_valid_q;
    if (a_fire) begin
      resp_d.opcode    = op_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      resp_d.size      = auto_in_a_bits_size;
      resp_d.source    = auto_in_a_bits_source;
      resp_d.denied    = ~legal;
      resp_d.corrupt   = op_get & ~legal;
      resp_d.use_rdata = op_get & legal;
      d_valid_d        = 1'b1;
    end else if (d_fire) begin
      d_valid_d        = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_q    <= '0;
      d_valid_q <= 1'b0;
    end else begin
      resp_q    <= resp_d;
      d_valid_q <= d_valid_d;
    end
  end

  tl_sram_responder_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .en    (a_fire & legal),
    .we    (op_put),
    .be    (auto_in_a_bits_mask),
    .idx   (word_idx),
    .wdata (auto_in_a_bits_data),
    .rdata (rdata)
  );

  assign auto_in_d_valid        = d_valid_q;
  assign auto_in_d_bits_opcode  = resp_q.opcode;
  assign auto_in_d_bits_param   = 2'b00;
  assign auto_in_d_bits_size    = resp_q.size;
  assign auto_in_d_bits_source  = resp_q.source;
  assign auto_in_d_bits_sink    = 1'b0;
  assign auto_in_d_bits_denied  = resp_q.denied;
  assign auto_in_d_bits_corrupt = resp_q.corrupt;
  assign auto_in_d_bits_data    = resp_q.use_rdata ? rdata : '0;

`ifdef TL_SRAM_RESPONDER_PERF_EN
  logic [31:0] req_cnt_q, req_cnt_d;
  logic [31:0] den_cnt_q, den_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    req_cnt_d   = sat_inc(req_cnt_q, a_fire);
    den_cnt_d   = sat_inc(den_cnt_q, a_fire & ~legal);
    stall_cnt_d = sat_inc(stall_cnt_q, d_valid_q & ~auto_in_d_ready);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_cnt_q   <= '0;
      den_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      den_cnt_q   <= den_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_req_count    = req_cnt_q;
  assign perf_denied_count = den_cnt_q;
  assign perf_stall_count  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tl_sram_responder.sv
// Bench for tl_sram_responder: directed vector table, hand sequences, then random traffic vs a reference model.
module tb_tl_sram_responder;

  localparam logic [28:0] BASE  = 29'h0001_0000;
  localparam int          DEPTH = 512;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [28:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [6:0]  src;
    logic        cor;
  } req_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [6:0]  src;
    logic        den;
    logic        cor;
    logic [63:0] data;
  } resp_t;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [28:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [6:0]  src;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_cor;
    logic [63:0] e_data;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [6:0]  a_source;
  logic [28:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_size;
  logic [1:0]  d_param;
  logic [6:0]  d_source;
  logic        d_sink, d_denied, d_corrupt;
  logic [63:0] d_data;
`ifdef TL_SRAM_RESPONDER_PERF_EN
  logic [31:0] perf_req, perf_den, perf_stall;
  int          mdl_req, mdl_den, mdl_stall;
`endif

  int    errors = 0;
  int    checks = 0;
  logic  exp_vld;
  resp_t exp_r;
  logic [63:0] mdl_mem [DEPTH];
  vec_t  vecs [17];

  always #5 clock = ~clock;

  tl_sram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_a_bits_corrupt (a_corrupt),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_param   (d_param),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_sink    (d_sink),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_corrupt (d_corrupt)
`ifdef TL_SRAM_RESPONDER_PERF_EN
    ,
    .perf_req_count         (perf_req),
    .perf_denied_count      (perf_den),
    .perf_stall_count       (perf_stall)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: legality from plain integer arithmetic, memory as a word array
  task automatic model_req(input req_t rq, output resp_t r);
    longint a     = longint'(rq.addr);
    bit     get   = (rq.op == 3'd4);
    bit     put   = (rq.op == 3'd0) || (rq.op == 3'd1);
    bit     legal;
    int     idx;
    legal = (get || put) && (rq.size <= 3) && ((a % (longint'(1) << rq.size)) == 0)
            && (a >= longint'(BASE)) && (a < longint'(BASE) + DEPTH * 8);
    idx = legal ? int'((a - longint'(BASE)) / 8) : 0;
    if (legal && put)
      for (int l = 0; l < 8; l++)
        if (rq.mask[l]) mdl_mem[idx][8*l +: 8] = rq.data[8*l +: 8];
    r.op   = get ? 3'd1 : 3'd0;
    r.size = rq.size;
    r.src  = rq.src;
    r.den  = !legal;
    r.cor  = get && !legal;
    r.data = (get && legal) ? mdl_mem[idx] : 64'd0;
  endtask

  task automatic cycle(input logic av, input req_t rq, input logic dr);
    logic  exp_ar;
    resp_t nr;
    a_valid = av;   a_opcode = rq.op; a_size = rq.size; a_address = rq.addr;
    a_mask = rq.mask; a_data = rq.data; a_source = rq.src; a_corrupt = rq.cor;
    a_param = 3'($urandom_range(0, 7));
    d_ready = dr;
    #1;
    exp_ar = !exp_vld || dr;
    chk("a_ready", 64'(a_ready), 64'(exp_ar));
`ifdef TL_SRAM_RESPONDER_PERF_EN
    if (exp_vld && !dr) mdl_stall++;
`endif
    @(posedge clock); #1;
    if (av && exp_ar) begin
      model_req(rq, nr);
      exp_r   = nr;
      exp_vld = 1'b1;
`ifdef TL_SRAM_RESPONDER_PERF_EN
      mdl_req++;
      if (nr.den) mdl_den++;
`endif
    end else if (exp_vld && dr) begin
      exp_vld = 1'b0;
    end
    chk("d_valid", 64'(d_valid), 64'(exp_vld));
    if (exp_vld) begin
      chk("d_opcode", 64'(d_opcode), 64'(exp_r.op));
      chk("d_size", 64'(d_size), 64'(exp_r.size));
      chk("d_source", 64'(d_source), 64'(exp_r.src));
      chk("d_denied", 64'(d_denied), 64'(exp_r.den));
      chk("d_corrupt", 64'(d_corrupt), 64'(exp_r.cor));
      chk("d_data", d_data, exp_r.data);
      chk("d_param_sink", 64'({d_param, d_sink}), 64'd0);
    end
  endtask

  function automatic req_t mk(input logic [2:0] op, input logic [2:0] size, input logic [28:0] addr,
                              input logic [7:0] mask, input logic [63:0] data, input logic [6:0] src);
    req_t r;
    r.op = op; r.size = size; r.addr = addr; r.mask = mask; r.data = data; r.src = src; r.cor = 1'b0;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t   r;
    int     k = $urandom_range(0, 15);
    int     w;
    longint a;
    r.op   = (k < 6) ? 3'd4 : (k < 9) ? 3'd0 : (k < 13) ? 3'd1 : 3'($urandom_range(0, 7));
    r.size = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    w      = ($urandom_range(0, 9) == 0) ? DEPTH - 1 : $urandom_range(0, 15);
    a      = longint'(BASE) + w * 8;
    if (r.size <= 3) a += ($urandom_range(0, 7) >> r.size) << r.size;
    if ($urandom_range(0, 7) == 0) a = longint'(BASE) + w * 8 + $urandom_range(0, 7);
    case ($urandom_range(0, 11))
      0:       a = longint'(BASE) + DEPTH * 8 + $urandom_range(0, 3) * 8;
      1:       a = longint'(BASE) - 8 * $urandom_range(1, 4);
      default: ;
    endcase
    r.addr = 29'(a);
    r.mask = 8'($urandom);
    r.data = {$urandom, $urandom};
    r.src  = 7'($urandom);
    r.cor  = 1'($urandom);
    return r;
  endfunction

  initial begin
    req_t  idle;
    resp_t held;
    idle = mk(3'd4, 3'd3, BASE, 8'hFF, 64'd0, 7'd0);
    vecs[0]  = '{3'd0, 3'd3, BASE + 29'h10, 8'hFF, 64'hDEAD_BEEF_0123_4567, 7'd5, 3'd0, 1'b0, 1'b0, 64'd0};
    vecs[1]  = '{3'd4, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'd6, 3'd1, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567};
    vecs[2]  = '{3'd1, 3'd3, BASE + 29'h10, 8'h0F, 64'd0, 7'd7, 3'd0, 1'b0, 1'b0, 64'd0};
    vecs[3]  = '{3'd4, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'd8, 3'd1, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0000};
    vecs[4]  = '{3'd4, 3'd3, BASE + 29'(DEPTH*8), 8'hFF, 64'd0, 7'd9, 3'd1, 1'b1, 1'b1, 64'd0};
    vecs[5]  = '{3'd4, 3'd2, BASE + 29'h2, 8'hFF, 64'd0, 7'd10, 3'd1, 1'b1, 1'b1, 64'd0};
    vecs[6]  = '{3'd2, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'd11, 3'd0, 1'b1, 1'b0, 64'd0};
    vecs[7]  = '{3'd4, 3'd3, BASE - 29'h8, 8'hFF, 64'd0, 7'd12, 3'd1, 1'b1, 1'b1, 64'd0};
    vecs[8]  = '{3'd0, 3'd3, BASE + 29'h14, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 7'd13, 3'd0, 1'b1, 1'b0, 64'd0};
    vecs[9]  = '{3'd1, 3'd2, BASE + 29'h14, 8'hF0, 64'h1111_2222_3333_4444, 7'd14, 3'd0, 1'b0, 1'b0, 64'd0};
    vecs[10] = '{3'd4, 3'd2, BASE + 29'h14, 8'hFF, 64'd0, 7'd15, 3'd1, 1'b0, 1'b0, 64'h1111_2222_0000_0000};
    vecs[11] = '{3'd0, 3'd3, BASE + 29'(DEPTH*8-8), 8'hFF, 64'h0123_4567_89AB_CDEF, 7'd16, 3'd0, 1'b0, 1'b0, 64'd0};
    vecs[12] = '{3'd4, 3'd4, BASE + 29'h10, 8'hFF, 64'd0, 7'd17, 3'd1, 1'b1, 1'b1, 64'd0};
    vecs[13] = '{3'd4, 3'd3, BASE + 29'(DEPTH*8-8), 8'hFF, 64'd0, 7'd18, 3'd1, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[14] = '{3'd1, 3'd0, BASE + 29'h13, 8'h08, 64'h0000_0000_AA00_0000, 7'd19, 3'd0, 1'b0, 1'b0, 64'd0};
    vecs[15] = '{3'd4, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'd20, 3'd1, 1'b0, 1'b0, 64'h1111_2222_AA00_0000};
    vecs[16] = '{3'd7, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'd21, 3'd0, 1'b1, 1'b0, 64'd0};

    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b0; exp_vld = 1'b0;
    a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd0; a_source = 7'd0;
    a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0;
`ifdef TL_SRAM_RESPONDER_PERF_EN
    mdl_req = 0; mdl_den = 0; mdl_stall = 0;
`endif
    repeat (3) @(posedge clock);
    a_valid = 1'b1; d_ready = 1'b1;
    #1;
    chk("reset_a_ready", 64'(a_ready), 64'd0);
    chk("reset_d_valid", 64'(d_valid), 64'd0);
    chk("reset_d_bits", 64'({d_opcode, d_size, d_source, d_denied, d_corrupt, d_param, d_sink}), 64'd0);
    chk("reset_d_data", d_data, 64'd0);
    a_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, mk(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].src), 1'b1);
      chk($sformatf("vec%0d_opcode", i), 64'(d_opcode), 64'(vecs[i].e_op));
      chk($sformatf("vec%0d_denied", i), 64'(d_denied), 64'(vecs[i].e_den));
      chk($sformatf("vec%0d_corrupt", i), 64'(d_corrupt), 64'(vecs[i].e_cor));
      chk($sformatf("vec%0d_data", i), d_data, vecs[i].e_data);
      chk($sformatf("vec%0d_source", i), 64'(d_source), 64'(vecs[i].src));
    end
    cycle(1'b0, idle, 1'b1);

    // Stall: response held five cycles with a request waiting, then released into a same-cycle A fire
    cycle(1'b1, mk(3'd4, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'd30), 1'b1);
    held = exp_r;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, mk(3'd4, 3'd3, BASE + 29'(DEPTH*8-8), 8'hFF, 64'd0, 7'd31), 1'b0);
      chk("stall_d_data", d_data, 64'h1111_2222_AA00_0000);
      chk("stall_d_source", 64'(d_source), 64'(held.src));
    end
    cycle(1'b1, mk(3'd4, 3'd3, BASE + 29'(DEPTH*8-8), 8'hFF, 64'd0, 7'd31), 1'b1);
    chk("release_source", 64'(d_source), 64'd31);
    chk("release_data", d_data, 64'h0123_4567_89AB_CDEF);
    cycle(1'b0, idle, 1'b1);

    // Back-to-back Gets
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, mk(3'd4, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'(40 + i)), 1'b1);
      chk("b2b_source", 64'(d_source), 64'(40 + i));
    end
    cycle(1'b0, idle, 1'b1);

    // Reset asserted while a response is pending
    cycle(1'b1, mk(3'd4, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'd70), 1'b0);
    a_valid = 1'b1; d_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("midreset_d_valid", 64'(d_valid), 64'd0);
    chk("midreset_a_ready", 64'(a_ready), 64'd0);
`ifdef TL_SRAM_RESPONDER_PERF_EN
    chk("perf_req_reset", 64'(perf_req), 64'd0);
    chk("perf_den_reset", 64'(perf_den), 64'd0);
    chk("perf_stall_reset", 64'(perf_stall), 64'd0);
    mdl_req = 0; mdl_den = 0; mdl_stall = 0;
`endif
    exp_vld = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    cycle(1'b1, mk(3'd4, 3'd3, BASE + 29'h10, 8'hFF, 64'd0, 7'd71), 1'b1);
    chk("postreset_data", d_data, 64'h1111_2222_AA00_0000);
    cycle(1'b0, idle, 1'b1);

    // Random traffic against the model; preload the words it may read
    for (int w = 0; w < 16; w++)
      cycle(1'b1, mk(3'd0, 3'd3, BASE + 29'(w * 8), 8'hFF, {$urandom, $urandom}, 7'(w)), 1'b1);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_req(), 1'($urandom_range(0, 3) != 0));
    cycle(1'b0, idle, 1'b1);

`ifdef TL_SRAM_RESPONDER_PERF_EN
    chk("perf_req", 64'(perf_req), 64'(mdl_req));
    chk("perf_den", 64'(perf_den), 64'(mdl_den));
    chk("perf_stall", 64'(perf_stall), 64'(mdl_stall));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_sram_responder.md
Name: tl_sram_responder

Overview:
- TileLink-UL responder (manager-side endpoint) backed by an internal byte-masked SRAM.
- Terminates the A channel and produces D-channel responses.
- Sits on the outward side of a TL buffer, where a request queue drains into it and a response queue is fed by it.
- Single-beat only: 64-bit data bus, transfers of at most 8 bytes.

Parameters:
- BASE_ADDR, 29'h0000_0000, byte address of word 0 of the window.
- DEPTH, 512, number of 64-bit words (power of two, ≥ 2).

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset
auto_in_a_valid  in  1  request valid
auto_in_a_ready  out  1  request accepted
auto_in_a_bits_opcode  in  3  0 = PutFull, 1 = PutPartial, 4 = Get; others unsupported
auto_in_a_bits_param  in  3  ignored
auto_in_a_bits_size  in  3  log2 bytes
auto_in_a_bits_source  in  7  requester ID
auto_in_a_bits_address  in  29  byte address
auto_in_a_bits_mask  in  8  byte lanes
auto_in_a_bits_data  in  64  write data
auto_in_a_bits_corrupt  in  1  write data poisoned
auto_in_d_valid  out  1  response valid
auto_in_d_ready  in  1  response accepted
auto_in_d_bits_opcode  out  3  0 = AccessAck, 1 = AccessAckData
auto_in_d_bits_param  out  2  always 0
auto_in_d_bits_size  out  3  echo of a_size
auto_in_d_bits_source  out  7  echo of a_source
auto_in_d_bits_sink  out  1  always 0
auto_in_d_bits_denied  out  1  request rejected
auto_in_d_bits_data  out  64  read data
auto_in_d_bits_corrupt  out  1  data poisoned

Behaviour:
- Reset (reset = 0, asynchronous assert, synchronous deassert expected): d_valid and all d_bits registers are 0; a_ready is forced 0 while reset is low. SRAM contents are not reset.
- A fire = a_valid & a_ready; D fire = d_valid & d_ready.
- One response register. a_ready = reset & (!d_valid | d_ready). Back-to-back requests sustain one per cycle.
- Latency: a response appears in d_bits/d_valid exactly 1 cycle after A fire. The SRAM read is synchronous and shares that cycle.
- d_valid next = A fire ? 1 : (D fire ? 0 : d_valid). When A fire and D fire coincide, the register is overwritten with the new response and d_valid stays 1.
- d_bits stay stable while d_valid & !d_ready.
- Legality checks (all must hold, else the request is denied):
  - opcode ∈ {0, 1, 4}
  - size ≤ 3
  - address aligned to 2^size
  - BASE_ADDR ≤ address < BASE_ADDR + DEPTH*8, compared in 30-bit arithmetic to avoid wrap
- Word index = (address − BASE_ADDR) >> 3, truncated to log2(DEPTH) bits.
- Legal Put: the SRAM write occurs on the A fire edge for byte lanes where mask is set. Response is AccessAck with denied = 0, corrupt = 0.
- Legal Put with a_corrupt = 1: the write is performed and a_corrupt is ignored by the store (corrupt tracking is out of scope).
- Legal Get: response is AccessAckData with data = full 64-bit word (mask not applied) and corrupt = 0.
- Denied request: no SRAM write.
  - Get → AccessAckData, denied = 1, corrupt = 1, data = 0.
  - Any other opcode → AccessAck, denied = 1, corrupt = 0.
- Read-after-write: a Get accepted the cycle after a Put to the same word returns the new data. No bypass is needed because the write lands on the prior edge.
- A reset asserted mid-operation drops any pending response, with no recovery of the lost transaction.

Optional Feature:
- Macro TL_SRAM_RESPONDER_PERF_EN.
- When defined, adds three ports:
  - perf_req_count  out 32: counts A fires.
  - perf_denied_count  out 32: counts denied responses at A fire.
  - perf_stall_count  out 32: counts cycles with d_valid & !d_ready.
- All three counters saturate at 32'hFFFF_FFFF and are reset to 0.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package tl_sram_responder_pkg holds:
  - A opcode constants (PUT_FULL, PUT_PARTIAL, GET) and D opcode constants (ACCESS_ACK, ACCESS_ACK_DATA).
  - Width localparams: SOURCE_W = 7, ADDR_W = 29, DATA_W = 64, MASK_W = 8.
  - A d_resp_t packed struct for the response register.
- One sub-module, tl_sram_responder_mem: DEPTH×64 synchronous-read RAM with 8-bit byte-write-enable. It has one port, where write and read are mutually exclusive per cycle.

Test Plan:
- PutFull addr BASE+0x10, data 64'hDEAD_BEEF_0123_4567, mask 8'hFF, source 5 → next cycle AccessAck, source 5, denied 0. Then Get at the same address, size 3 → AccessAckData, data 64'hDEAD_BEEF_0123_4567.
- PutPartial addr BASE+0x10, mask 8'h0F, data 64'h0 → Get returns 64'hDEAD_BEEF_0000_0000.
- Get addr BASE+DEPTH*8 → AccessAckData, denied 1, corrupt 1, data 0. Get size 2 at addr BASE+0x2 → denied 1 (misaligned). Opcode 2 → AccessAck, denied 1.
- d_ready held 0 for 5 cycles after a Get: a_ready is 0, d_bits are stable, and no new A accepted. Release d_ready with a_valid high → same-cycle A fire, and the next response follows with no bubble.
- 20 back-to-back Gets with d_ready = 1 → 20 responses on consecutive cycles, sources in issue order.
- Drive reset low while d_valid = 1 → d_valid is 0 immediately (asynchronous) and a_ready is 0. After release, a Get completes normally. With TL_SRAM_RESPONDER_PERF_EN defined, the counters read 0 after reset.
